// File: rtl/matrixops_pkg.sv
// Shared definitions for the matrixops_gen engine: operation codes, FSM states
// and the derived result-element width.
package matrixops_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_TRN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Wide enough for a full N-term dot product of W-bit operands.
    function automatic int calc_rw(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/matrixops_alu.sv
// Combinational datapath: one MAC step for multiply, a single-step result for
// add, subtract and transpose. Operands are zero-extended to the result width.
module matrixops_alu
    import matrixops_pkg::*;
#(
    parameter int W  = 2,
    parameter int RW = 5
) (
    input  logic [1:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [RW-1:0] acc,
    output logic [RW-1:0] y
);

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;

    always_comb begin
        a_ext = RW'(a);
        b_ext = RW'(b);
        y     = a_ext;
        case (op)
            OP_ADD:  y = a_ext + b_ext;
            OP_SUB:  y = a_ext - b_ext;
            OP_MUL:  y = acc + (a_ext * b_ext);
            default: y = a_ext;
        endcase
    end

endmodule

// File: rtl/matrixops_gen.sv
// NxN matrix engine: loads A and B element by element, computes add/sub/mul/
// transpose per result element and streams each result serially, MSB first.
module matrixops_gen
    import matrixops_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enter,
    input  logic [1:0]   op,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic         ready,
    output logic         Z,
    output logic         z_valid,
    output logic         done
);

    localparam int RW = calc_rw(N, W);
    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int CW = $clog2(N);
    localparam int BW = $clog2(RW);

    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
    localparam logic [CW-1:0] LAST_RC  = CW'(N - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(RW - 1);

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [IW-1:0] ld_idx_q, ld_idx_d;
    logic [CW-1:0] r_q, r_d, c_q, c_d, k_q, k_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [RW-1:0] sh_q, sh_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          z_q, z_d;
    logic          z_valid_q, z_valid_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          mem_we;
    logic          compute_last;

    logic [W-1:0]  a_mem_q [NN];
    logic [W-1:0]  b_mem_q [NN];
    logic [IW-1:0] a_idx, b_idx;
    logic [W-1:0]  alu_a, alu_b;
    logic [RW-1:0] alu_y;

    // Operand addressing: multiply walks k along A's row and B's column.
    always_comb begin
        a_idx = IW'(int'(r_q) * N + int'(c_q));
        b_idx = a_idx;
        if (op_q == OP_MUL) begin
            a_idx = IW'(int'(r_q) * N + int'(k_q));
            b_idx = IW'(int'(k_q) * N + int'(c_q));
        end else if (op_q == OP_TRN) begin
            a_idx = IW'(int'(c_q) * N + int'(r_q));
        end
        alu_a = a_mem_q[a_idx];
        alu_b = b_mem_q[b_idx];
    end

    matrixops_alu #(.W(W), .RW(RW)) u_alu (
        .op  (op_q),
        .a   (alu_a),
        .b   (alu_b),
        .acc (acc_q),
        .y   (alu_y)
    );

    assign compute_last = (op_q != OP_MUL) || (k_q == LAST_RC);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ld_idx_d  = ld_idx_q;
        r_d       = r_q;
        c_d       = c_q;
        k_d       = k_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        z_d       = 1'b0;
        z_valid_d = 1'b0;
        done_d    = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enter) begin
                    mem_we   = 1'b1;
                    op_d     = op;
                    ld_idx_d = IW'(1);
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (enter) begin
                    mem_we = 1'b1;
                    if (ld_idx_q == LAST_IDX) begin
                        ld_idx_d = '0;
                        r_d      = '0;
                        c_d      = '0;
                        k_d      = '0;
                        acc_d    = '0;
                        state_d  = ST_COMPUTE;
                    end else begin
                        ld_idx_d = ld_idx_q + IW'(1);
                    end
                end
            end
            ST_COMPUTE: begin
                acc_d = alu_y;
                if (compute_last) begin
                    // First result bit is presented on entry to SHIFT.
                    sh_d      = alu_y << 1;
                    z_d       = alu_y[RW-1];
                    z_valid_d = 1'b1;
                    bit_d     = '0;
                    k_d       = '0;
                    state_d   = ST_SHIFT;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            ST_SHIFT: begin
                if (bit_q == LAST_BIT) begin
                    if ((r_q == LAST_RC) && (c_q == LAST_RC)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        if (c_q == LAST_RC) begin
                            c_d = '0;
                            r_d = r_q + CW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                        acc_d   = '0;
                        state_d = ST_COMPUTE;
                    end
                end else begin
                    z_d       = sh_q[RW-1];
                    z_valid_d = 1'b1;
                    sh_d      = sh_q << 1;
                    bit_d     = bit_q + BW'(1);
                end
            end
            ST_DONE: begin
                r_d     = '0;
                c_d     = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            ld_idx_q  <= '0;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            bit_q     <= '0;
            z_q       <= 1'b0;
            z_valid_q <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ld_idx_q  <= ld_idx_d;
            r_q       <= r_d;
            c_q       <= c_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    // Matrix storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            a_mem_q[ld_idx_q] <= X;
            b_mem_q[ld_idx_q] <= Y;
        end
    end

    assign ready   = ready_q;
    assign Z       = z_q;
    assign z_valid = z_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_matrixops_gen.sv
// Directed self-checking bench for matrixops_gen with N=2, W=2 (5-bit results).
module tb_matrixops_gen;

    typedef int vec4_t [4];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enter = 1'b0;
    logic [1:0] op = 2'b00;
    logic [1:0] X = 2'b00;
    logic [1:0] Y = 2'b00;
    logic       ready, Z, z_valid, done;

    int    tests_run = 0;
    int    tests_failed = 0;
    vec4_t xs, ys, gaps, expv;

    matrixops_gen #(.N(2), .W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .enter   (enter),
        .op      (op),
        .X       (X),
        .Y       (Y),
        .ready   (ready),
        .Z       (Z),
        .z_valid (z_valid),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Loads xs/ys with the given enter gaps; op is toggled after the first element.
    task automatic applyStimulus(input logic [1:0] op_sel);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            enter = 1'b0;
            repeat (gaps[i]) begin
                @(posedge clk); #1;
            end
            enter = 1'b1;
            X     = 2'(xs[i]);
            Y     = 2'(ys[i]);
            op    = (i == 0) ? op_sel : ~op_sel;
            @(posedge clk); #1;
        end
        enter = 1'b0;
        op    = ~op_sel;
    endtask

    task automatic collectResults(input string tag, input int tc);
        int results [4];
        int bits, group, valid_cnt, idle_cnt, ready_hi, z_bad, done_at;
        logic [4:0] word;
        bits = 0; group = 0; valid_cnt = 0; idle_cnt = 0;
        ready_hi = 0; z_bad = 0; done_at = -1; word = '0;
        for (int g = 0; g < 4; g++) results[g] = -1;
        for (int cyc = 1; cyc <= 200 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (ready) ready_hi++;
            if (done) begin
                done_at = cyc - 1;
            end else if (z_valid) begin
                word = {word[3:0], Z};
                bits++;
                valid_cnt++;
                if (bits == 5) begin
                    if (group < 4) results[group] = int'(word);
                    group++;
                    bits = 0;
                end
            end else begin
                idle_cnt++;
                if (Z) z_bad++;
            end
        end
        checkOutput({tag, "_done_latency"}, done_at, 4 * (tc + 5));
        for (int g = 0; g < 4; g++)
            checkOutput($sformatf("%s_res%0d", tag, g), results[g], expv[g]);
        checkOutput({tag, "_valid_bits"}, valid_cnt, 20);
        checkOutput({tag, "_idle_cycles"}, idle_cnt, 4 * tc);
        checkOutput({tag, "_z_when_invalid"}, z_bad, 0);
        checkOutput({tag, "_ready_during_output"}, ready_hi, 0);
        @(negedge clk);
        checkOutput({tag, "_done_single_pulse"}, int'(done), 0);
        checkOutput({tag, "_ready_after_done"}, int'(ready), 1);
    endtask

    initial begin
        int found;
        #12;
        checkOutput("reset_ready", int'(ready), 1);
        checkOutput("reset_z", int'(Z), 0);
        checkOutput("reset_z_valid", int'(z_valid), 0);
        checkOutput("reset_done", int'(done), 0);
        #5 rst = 1'b1;

        xs = '{2, 1, 1, 3}; ys = '{0, 1, 3, 3}; gaps = '{0, 0, 0, 0};
        expv = '{3, 5, 9, 10};
        applyStimulus(2'b10);
        collectResults("mul", 2);

        xs = '{3, 3, 3, 3}; ys = '{3, 3, 3, 3};
        expv = '{6, 6, 6, 6};
        applyStimulus(2'b00);
        collectResults("add", 1);

        xs = '{0, 0, 0, 0}; ys = '{1, 1, 1, 1};
        expv = '{31, 31, 31, 31};
        applyStimulus(2'b01);
        collectResults("sub", 1);

        xs = '{0, 1, 2, 3}; ys = '{3, 2, 1, 0};
        expv = '{0, 2, 1, 3};
        applyStimulus(2'b11);
        collectResults("trn", 1);

        xs = '{2, 1, 1, 3}; ys = '{0, 1, 3, 3}; gaps = '{0, 1, 3, 1};
        expv = '{3, 5, 9, 10};
        applyStimulus(2'b10);
        collectResults("mul_gaps", 2);

        gaps = '{0, 0, 0, 0};
        applyStimulus(2'b10);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (z_valid && Z) found = 1;
        end
        checkOutput("abort_reached_shift", found, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_z", int'(Z), 0);
        checkOutput("abort_z_valid", int'(z_valid), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_ready", int'(ready), 1);
        @(posedge clk); #1;
        rst = 1'b1;

        applyStimulus(2'b10);
        collectResults("mul_after_abort", 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
